// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the 16-bit 5-stage pipeline: branch
//                condition codes, M/WB control-bit positions and flag-bit
//                positions. Used by EX, the EX->MEM register and MEM_slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   // Branch condition codes evaluated in MEM against the flag register.
   typedef enum logic [2:0] {
      COND_EQ     = 3'h0,
      COND_NE     = 3'h1,
      COND_LT     = 3'h2,
      COND_GE     = 3'h3,
      COND_GT     = 3'h4,
      COND_LE     = 3'h5,
      COND_VS     = 3'h6,
      COND_UNCOND = 3'h7
   } cond_t;

   // M control vector {branch, MemWrite, MemRead}
   localparam int M_MEMREAD  = 0;
   localparam int M_MEMWRITE = 1;
   localparam int M_BRANCH   = 2;
   localparam int M_W        = 3;

   // WB control vector {MemToReg, RegWrite}
   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;
   localparam int WB_W        = 2;

   // Flag vector {ov, neg, zr}
   localparam int FLAG_ZR  = 0;
   localparam int FLAG_NEG = 1;
   localparam int FLAG_OV  = 2;
   localparam int FLAG_W   = 3;

   // Masked merge: bits selected by we take new value, others keep old.
   function automatic logic [FLAG_W-1:0] flag_merge(
      input logic [FLAG_W-1:0] old_val,
      input logic [FLAG_W-1:0] new_val,
      input logic [FLAG_W-1:0] we
   );
      return (old_val & ~we) | (new_val & we);
   endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/flag_reg.sv
`default_nettype none
// ============================================================================
//  Module      : flag_reg
//  Description : Architectural Z/N/V flag register with per-bit write mask.
//                When en is high, bits selected by we load d; all other
//                bits (and all bits when en is low) hold.
//  Ports       : clk, rst (sync, active-high), en, we[2:0], d[2:0] -> q[2:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_reg
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [FLAG_W-1:0] we,
   input  logic [FLAG_W-1:0] d,
   output logic [FLAG_W-1:0] q
);

   logic [FLAG_W-1:0] flags_d;
   logic [FLAG_W-1:0] flags_q;

   always_comb begin
      flags_d = flags_q;
      if (en) begin
         flags_d = flag_merge(flags_q, d, we);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign q = flags_q;

endmodule : flag_reg
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_reg
//  Description : EX->MEM pipeline register. Carries control/data of the EX
//                instruction into MEM with one cycle latency, owns the flag
//                register, supports stall (hold) and flush (bubble), exposes
//                MEM-stage forwarding info and a combinational load-use
//                hazard for ID, and counts inserted bubbles (saturating).
//  Ports       : clk, rst, stall, flush, ex_* (EX instr), id_src1/2 (hazard)
//                -> mem_valid, M, WB, flags, bcond, addr, alu, wdata,
//                   pcbranch, dst, fwd_valid, load_use, bubble_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg
   import pipe_pkg::*;
#(
   parameter int DW   = 16,
   parameter int RW   = 4,
   parameter int CNTW = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [M_W-1:0]    ex_M,
   input  logic [WB_W-1:0]   ex_WB,
   input  logic [FLAG_W-1:0] ex_flags,
   input  logic [FLAG_W-1:0] ex_flag_we,
   input  logic [2:0]        ex_bcond,
   input  logic [DW-1:0]     ex_alu,
   input  logic [DW-1:0]     ex_wdata,
   input  logic [DW-1:0]     ex_pcbranch,
   input  logic [RW-1:0]     ex_dst,
   input  logic [RW-1:0]     id_src1,
   input  logic [RW-1:0]     id_src2,
   output logic              mem_valid,
   output logic [M_W-1:0]    M,
   output logic [WB_W-1:0]   WB,
   output logic [FLAG_W-1:0] flags,
   output logic [2:0]        bcond,
   output logic [DW-1:0]     addr,
   output logic [DW-1:0]     alu,
   output logic [DW-1:0]     wdata,
   output logic [DW-1:0]     pcbranch,
   output logic [RW-1:0]     dst,
   output logic              fwd_valid,
   output logic              load_use,
   output logic [CNTW-1:0]   bubble_cnt
);

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   logic              valid_d,    valid_q;
   logic [M_W-1:0]    m_d,        m_q;
   logic [WB_W-1:0]   wb_d,       wb_q;
   cond_t             bcond_d,    bcond_q;
   logic [DW-1:0]     alu_d,      alu_q;
   logic [DW-1:0]     wdata_d,    wdata_q;
   logic [DW-1:0]     pcbranch_d, pcbranch_q;
   logic [RW-1:0]     dst_d,      dst_q;
   logic [CNTW-1:0]   bcnt_d,     bcnt_q;

   logic advance;
   logic bubble;

   // advance: EX instruction (real or not) moves into MEM.
   // bubble : MEM receives a non-instruction this edge (flush, or an
   //          empty EX slot advancing).
   assign advance = !stall && !flush;
   assign bubble  = !stall && (flush || !ex_valid);

   always_comb begin
      valid_d    = valid_q;
      m_d        = m_q;
      wb_d       = wb_q;
      bcond_d    = bcond_q;
      alu_d      = alu_q;
      wdata_d    = wdata_q;
      pcbranch_d = pcbranch_q;
      dst_d      = dst_q;
      bcnt_d     = bcnt_q;

      if (!stall) begin
         if (flush) begin
            // Bubble: kill control, leave data registers as they were.
            valid_d = 1'b0;
            m_d     = '0;
            wb_d    = '0;
            bcond_d = COND_EQ;
         end else begin
            valid_d    = ex_valid;
            m_d        = ex_valid ? ex_M  : '0;
            wb_d       = ex_valid ? ex_WB : '0;
            bcond_d    = cond_t'(ex_bcond);
            alu_d      = ex_alu;
            wdata_d    = ex_wdata;
            pcbranch_d = ex_pcbranch;
            dst_d      = ex_dst;
         end
      end

      if (bubble && (bcnt_q != {CNTW{1'b1}})) begin
         bcnt_d = bcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         m_q        <= '0;
         wb_q       <= '0;
         bcond_q    <= COND_EQ;
         alu_q      <= '0;
         wdata_q    <= '0;
         pcbranch_q <= '0;
         dst_q      <= '0;
         bcnt_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         m_q        <= m_d;
         wb_q       <= wb_d;
         bcond_q    <= bcond_d;
         alu_q      <= alu_d;
         wdata_q    <= wdata_d;
         pcbranch_q <= pcbranch_d;
         dst_q      <= dst_d;
         bcnt_q     <= bcnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Flag register: only a real instruction that advances may update it,
   // so a branch reaching MEM sees the most recent preceding flag-setter.
   // ------------------------------------------------------------------
   flag_reg u_flag_reg (
      .clk (clk),
      .rst (rst),
      .en  (advance && ex_valid),
      .we  (ex_flag_we),
      .d   (ex_flags),
      .q   (flags)
   );

   // ------------------------------------------------------------------
   // Hazard / forwarding. R0 is hardwired zero, so it is never a source.
   // ------------------------------------------------------------------
   logic src_match;
   assign src_match = (ex_dst == id_src1) || (ex_dst == id_src2);

   assign load_use = ex_valid && ex_M[M_MEMREAD] && ex_WB[WB_REGWRITE] &&
                     (ex_dst != '0) && src_match && !flush;

   // A load's alu field is only the address, so MemToReg blocks forwarding.
   assign fwd_valid = valid_q && wb_q[WB_REGWRITE] && !wb_q[WB_MEMTOREG] &&
                      (dst_q != '0);

   // ------------------------------------------------------------------
   // Outputs: addr and alu are the same registered ALU result.
   // ------------------------------------------------------------------
   assign mem_valid  = valid_q;
   assign M          = m_q;
   assign WB         = wb_q;
   assign bcond      = bcond_q;
   assign addr       = alu_q;
   assign alu        = alu_q;
   assign wdata      = wdata_q;
   assign pcbranch   = pcbranch_q;
   assign dst        = dst_q;
   assign bubble_cnt = bcnt_q;

endmodule : ex_mem_reg
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_reg
//  Description : Self-checking bench for ex_mem_reg. A behavioural model of
//                the pipeline register is advanced on every rising edge and
//                compared against the DUT on every falling edge; directed
//                scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_reg;

   localparam int DW   = 16;
   localparam int RW   = 4;
   localparam int CNTW = 16;

   logic            clk = 1'b0;
   logic            rst, stall, flush, ex_valid;
   logic [2:0]      ex_M, ex_flags, ex_flag_we, ex_bcond;
   logic [1:0]      ex_WB;
   logic [DW-1:0]   ex_alu, ex_wdata, ex_pcbranch;
   logic [RW-1:0]   ex_dst, id_src1, id_src2;

   logic            mem_valid, fwd_valid, load_use;
   logic [2:0]      M, flags, bcond;
   logic [1:0]      WB;
   logic [DW-1:0]   addr, alu, wdata, pcbranch;
   logic [RW-1:0]   dst;
   logic [CNTW-1:0] bubble_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ex_mem_reg #(.DW(DW), .RW(RW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_M(ex_M), .ex_WB(ex_WB),
      .ex_flags(ex_flags), .ex_flag_we(ex_flag_we), .ex_bcond(ex_bcond),
      .ex_alu(ex_alu), .ex_wdata(ex_wdata), .ex_pcbranch(ex_pcbranch),
      .ex_dst(ex_dst), .id_src1(id_src1), .id_src2(id_src2),
      .mem_valid(mem_valid), .M(M), .WB(WB), .flags(flags), .bcond(bcond),
      .addr(addr), .alu(alu), .wdata(wdata), .pcbranch(pcbranch),
      .dst(dst), .fwd_valid(fwd_valid), .load_use(load_use),
      .bubble_cnt(bubble_cnt)
   );

   // ------------------------------------------------------------------
   // Behavioural model: what MEM must hold after each edge.
   // ------------------------------------------------------------------
   bit          e_valid  = 0;
   bit  [2:0]   e_M      = 0;
   bit  [1:0]   e_WB     = 0;
   bit  [2:0]   e_flags  = 0;
   bit  [2:0]   e_bcond  = 0;
   bit  [15:0]  e_alu    = 0;
   bit  [15:0]  e_wdata  = 0;
   bit  [15:0]  e_pcb    = 0;
   bit  [3:0]   e_dst    = 0;
   int unsigned e_bubbles = 0;

   always @(posedge clk) begin
      if (rst) begin
         e_valid = 0; e_M = 0; e_WB = 0; e_flags = 0; e_bcond = 0;
         e_alu = 0; e_wdata = 0; e_pcb = 0; e_dst = 0; e_bubbles = 0;
      end else if (!stall) begin
         if (flush) begin
            e_valid = 0; e_M = 0; e_WB = 0; e_bcond = 0;
            e_bubbles++;
         end else begin
            e_valid = ex_valid;
            e_M     = ex_valid ? ex_M  : 3'b000;
            e_WB    = ex_valid ? ex_WB : 2'b00;
            e_bcond = ex_bcond;
            e_alu   = ex_alu;
            e_wdata = ex_wdata;
            e_pcb   = ex_pcbranch;
            e_dst   = ex_dst;
            if (ex_valid) begin
               for (int i = 0; i < 3; i++)
                  if (ex_flag_we[i]) e_flags[i] = ex_flags[i];
            end else begin
               e_bubbles++;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Single compare process: every falling edge once checking is enabled.
   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_lu;
         int unsigned sat;
         sat = (e_bubbles > 32'h0000FFFF) ? 32'h0000FFFF : e_bubbles;
         exp_lu = 0;
         if (ex_valid && ex_M[0] && ex_WB[0] && ex_dst != 0 && !flush)
            exp_lu = (ex_dst == id_src1) || (ex_dst == id_src2);
         check("mem_valid", {31'b0, mem_valid}, {31'b0, e_valid});
         check("M",         {29'b0, M},         {29'b0, e_M});
         check("WB",        {30'b0, WB},        {30'b0, e_WB});
         check("flags",     {29'b0, flags},     {29'b0, e_flags});
         check("bcond",     {29'b0, bcond},     {29'b0, e_bcond});
         check("addr",      {16'b0, addr},      {16'b0, e_alu});
         check("alu",       {16'b0, alu},       {16'b0, e_alu});
         check("wdata",     {16'b0, wdata},     {16'b0, e_wdata});
         check("pcbranch",  {16'b0, pcbranch},  {16'b0, e_pcb});
         check("dst",       {28'b0, dst},       {28'b0, e_dst});
         check("fwd_valid", {31'b0, fwd_valid},
               {31'b0, e_valid && e_WB == 2'b01 && e_dst != 0});
         check("load_use",  {31'b0, load_use},  {31'b0, exp_lu});
         check("bubble_cnt", {16'b0, bubble_cnt}, sat);
      end
   end

   // Inputs change 2 time units after the rising edge.
   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      stall = 0; flush = 0; ex_valid = 1; ex_M = 0; ex_WB = 0;
      ex_flags = 0; ex_flag_we = 0; ex_bcond = 0; ex_alu = 0;
      ex_wdata = 0; ex_pcbranch = 0; ex_dst = 0; id_src1 = 0; id_src2 = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      cyc(2);
      chk_en = 1;
      // Reset state
      check("lit_reset_valid", {31'b0, mem_valid}, 0);
      check("lit_reset_cnt",   {16'b0, bubble_cnt}, 0);
      check("lit_reset_flags", {29'b0, flags}, 0);
      rst = 0;

      // Basic advance
      ex_valid = 1; ex_alu = 16'h1234; ex_M = 3'b001; ex_wdata = 16'h00AA;
      ex_pcbranch = 16'h0040; ex_dst = 4'd7; ex_bcond = 3'h7;
      cyc();
      check("lit_adv_addr",  {16'b0, addr}, 32'h1234);
      check("lit_adv_alu",   {16'b0, alu},  32'h1234);
      check("lit_adv_M",     {29'b0, M},    32'h1);
      check("lit_adv_valid", {31'b0, mem_valid}, 1);

      // Flag setter A then non-setting branch B
      ex_M = 3'b000; ex_flags = 3'b001; ex_flag_we = 3'b111; ex_bcond = 3'h0;
      cyc();
      ex_M = 3'b100; ex_flags = 3'b110; ex_flag_we = 3'b000; ex_alu = 16'h5555;
      cyc();
      check("lit_flags_B",   {29'b0, flags}, 32'h1);
      check("lit_branch_M",  {29'b0, M},     32'h4);
      // Partial mask: only neg updated
      ex_M = 3'b000; ex_flags = 3'b110; ex_flag_we = 3'b010;
      cyc();
      check("lit_flags_mask", {29'b0, flags}, 32'h3);

      // Stall 3 cycles with flush held; then flush alone
      ex_alu = 16'h9999; stall = 1; flush = 1;
      cyc(3);
      check("lit_stall_cnt",  {16'b0, bubble_cnt}, 0);
      check("lit_stall_addr", {16'b0, addr}, 32'h5555);
      check("lit_stall_valid", {31'b0, mem_valid}, 1);
      stall = 0;
      cyc();
      check("lit_flush_valid", {31'b0, mem_valid}, 0);
      check("lit_flush_cnt",   {16'b0, bubble_cnt}, 1);
      check("lit_flush_addr",  {16'b0, addr}, 32'h5555);
      flush = 0;

      // Load-use (combinational)
      ex_M = 3'b001; ex_WB = 2'b01; ex_dst = 4'd5; id_src1 = 4'd2; id_src2 = 4'd5;
      #1 check("lit_lu_hit", {31'b0, load_use}, 1);
      ex_dst = 4'd0; id_src2 = 4'd0;
      #1 check("lit_lu_r0", {31'b0, load_use}, 0);
      ex_dst = 4'd2; flush = 1;
      #1 check("lit_lu_flush", {31'b0, load_use}, 0);
      flush = 0;
      cyc();

      // Forwarding
      ex_M = 3'b000; ex_WB = 2'b01; ex_dst = 4'd3; ex_alu = 16'hBEEF;
      cyc();
      check("lit_fwd_on",  {31'b0, fwd_valid}, 1);
      check("lit_fwd_alu", {16'b0, alu}, 32'hBEEF);
      ex_WB = 2'b11;
      cyc();
      check("lit_fwd_load", {31'b0, fwd_valid}, 0);
      ex_WB = 2'b01; ex_dst = 4'd0;
      cyc();
      check("lit_fwd_r0", {31'b0, fwd_valid}, 0);

      // Invalid EX advancing counts as a bubble and forces control off
      ex_valid = 0; ex_M = 3'b111; ex_WB = 2'b11;
      cyc();
      check("lit_inv_M",   {29'b0, M}, 0);
      check("lit_inv_cnt", {16'b0, bubble_cnt}, 2);
      ex_valid = 1; ex_M = 0; ex_WB = 0;

      // Reset mid-stall/flush: reset wins
      stall = 1; flush = 1; rst = 1;
      cyc();
      rst = 0; stall = 0; flush = 0;
      check("lit_rst_mid_cnt",   {16'b0, bubble_cnt}, 0);
      check("lit_rst_mid_valid", {31'b0, mem_valid}, 0);

      // Saturation: count up to FFFE then two more flushes
      flush = 1;
      cyc(65534);
      check("lit_sat_fffe", {16'b0, bubble_cnt}, 32'hFFFE);
      cyc(2);
      check("lit_sat_ffff", {16'b0, bubble_cnt}, 32'hFFFF);
      flush = 0; rst = 1;
      cyc();
      rst = 0;
      check("lit_sat_rst", {16'b0, bubble_cnt}, 0);
      cyc(2);

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ex_mem_reg
`default_nettype wire
